// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, frame-sequencer state encoding and opcode legality check.
// Used by alu_uart_ctrl and by the ALU bench so both agree on the legal opcode set.
package alu_pkg;

  localparam int NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  function automatic logic is_legal_op(input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_legal_op = 1'b1;
      default:                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear, flags expiry at TIMEOUT_CYCLES-1.
// o_expire is combinational from the count; the counter restarts on clear, disable or expiry.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] cnt;

  assign o_expire = i_en && (cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clear || !i_en || o_expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Frame sequencer UART RX -> ALU -> UART TX: collects A, B, OP bytes, latches the ALU result, starts TX.
// OP strobe at N -> tx_start at N+2; RX bytes are dropped while busy, frame completes on tx_done.
module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_alu_data_A,
  output logic [NB_DATA-1:0] o_alu_data_B,
  output logic [NB_OP-1:0]   o_alu_OP,
  input  logic [NB_DATA-1:0] i_alu_data_RES,
  output logic               o_busy,
  output logic               o_op_err,
  output logic               o_timeout
);

  import alu_pkg::*;

  state_t state;
  logic   timer_en;
  logic   timer_clr;
  logic   gap_expire;

  // The timer only runs while a frame is partially received; any accepted byte restarts it.
  assign timer_en  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  assign timer_clr = i_rx_done || !timer_en;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (timer_clr),
    .i_en    (timer_en),
    .o_expire(gap_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_alu_data_A <= '0;
      o_alu_data_B <= '0;
      o_alu_OP     <= '0;
      o_busy       <= 1'b0;
      o_op_err     <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_done) begin
            o_alu_data_A <= i_rx_data;
            state        <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          // A byte arriving in the expiry cycle takes priority over the abort.
          if (i_rx_done) begin
            o_alu_data_B <= i_rx_data;
            state        <= ST_WAIT_OP;
          end else if (gap_expire) begin
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_done) begin
            if (is_legal_op(i_rx_data[NB_OP-1:0])) begin
              o_alu_OP <= i_rx_data[NB_OP-1:0];
              o_busy   <= 1'b1;
              state    <= ST_EXEC;
            end else begin
              o_op_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end else if (gap_expire) begin
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          o_tx_data  <= i_alu_data_RES;
          o_op_err   <= 1'b0;
          o_tx_start <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Randomized and directed bench for alu_uart_ctrl against a frame-level reference model.
// A behavioural ALU closes the loop between o_alu_* and i_alu_data_RES.
module tb_alu_uart_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TMO     = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NB_DATA-1:0] rx_data = '0;
  logic               rx_done = 1'b0;
  logic               tx_done = 1'b0;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] alu_res;
  logic               busy;
  logic               op_err;
  logic               timeout;

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;
  int to_pulses = 0;
  int exp_tx = 0;
  logic [NB_OP-1:0] last_op = '0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit legal_model(input logic [5:0] op);
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  endfunction

  assign alu_res = alu_model(alu_a, alu_b, alu_op);

  alu_uart_ctrl #(
    .NB_DATA(NB_DATA),
    .NB_OP(NB_OP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_tx_done(tx_done),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_alu_data_A(alu_a),
    .o_alu_data_B(alu_b),
    .o_alu_OP(alu_op),
    .i_alu_data_RES(alu_res),
    .o_busy(busy),
    .o_op_err(op_err),
    .o_timeout(timeout)
  );

  always @(negedge clk) begin
    if (tx_start) tx_pulses++;
    if (timeout) to_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {tx_data, tx_start, alu_a, alu_b, alu_op, busy, op_err, timeout}, 32'h0);
  endtask

  // One frame with gap cycles between bytes and txd cycles before tx_done; junk exercises busy drops.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input int gap, input int txd, input bit junk);
    logic [7:0] exp_res;
    bit         legal;
    int         t0;
    legal   = legal_model(op[5:0]);
    exp_res = alu_model(a, b, op[5:0]);
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    t0 = tx_pulses;
    send_byte(op);
    chk("opA", alu_a, a);
    chk("opB", alu_b, b);
    if (legal) begin
      chk("op_latch", alu_op, op[5:0]);
      chk("busy_exec", busy, 1);
      chk("start_exec", tx_start, 0);
      tick();
      if (junk) tx_done = 1'b1;
      chk("start_send", tx_start, 1);
      chk("tx_data", tx_data, exp_res);
      chk("operr_clr", op_err, 0);
      tick();
      tx_done = 1'b0;
      chk("start_once", tx_start, 0);
      chk("busy_wait", busy, 1);
      if (junk) begin
        for (int i = 0; i < txd / 2; i++) send_byte(8'($urandom));
        chk("busy_hold", busy, 1);
        chk("drop_A", alu_a, a);
        chk("drop_B", alu_b, b);
      end else begin
        idle(txd);
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("busy_done", busy, 0);
      chk("tx_stable", tx_data, exp_res);
      chk("tx_count", tx_pulses - t0, 1);
      exp_tx++;
      last_op = op[5:0];
    end else begin
      chk("operr_set", op_err, 1);
      chk("op_hold", alu_op, last_op);
      chk("busy_ill", busy, 0);
      idle(3);
      chk("no_tx", tx_pulses - t0, 0);
    end
  endtask

  initial begin
    logic [7:0] a, b, op;
    logic [5:0] legal_ops [8];
    int         t;
    legal_ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    idle(2);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);
    chk_zero("post_reset");

    frame(8'h05, 8'h03, 8'h20, 1, 3, 0);
    chk("add_res", tx_data, 8'h08);
    frame(8'h03, 8'h05, 8'h22, 0, 50, 1);
    chk("sub_res", tx_data, 8'hFE);
    frame(8'h80, 8'h02, 8'h03, 2, 1, 0);
    chk("sra_res", tx_data, 8'hE0);
    frame(8'h80, 8'h02, 8'h02, 0, 0, 0);
    chk("srl_res", tx_data, 8'h20);

    // Gap timeout after A,B, then a normal frame
    t = to_pulses;
    send_byte(8'h11);
    send_byte(8'h22);
    idle(TMO - 2);
    chk("no_early_to", to_pulses - t, 0);
    idle(8);
    chk("to_once", to_pulses - t, 1);
    chk("to_idle_busy", busy, 0);
    frame(8'h01, 8'h01, 8'h25, 0, 2, 0);
    chk("to_frame_res", tx_data, 8'h01);

    // Byte in the expiry cycle is accepted
    t = to_pulses;
    frame(8'h0C, 8'h0A, 8'h26, TMO - 2, 1, 0);
    chk("edge_no_to", to_pulses - t, 0);
    chk("edge_res", tx_data, 8'h06);

    // One cycle later the frame is aborted and the late byte starts a new frame
    t = to_pulses;
    send_byte(8'h44);
    idle(TMO - 1);
    frame(8'h09, 8'h04, 8'h22, 0, 1, 0);
    chk("late_to", to_pulses - t, 1);
    chk("late_res", tx_data, 8'h05);

    // Illegal opcode, then a legal frame clears the flag
    frame(8'h01, 8'h02, 8'h3F, 0, 0, 0);
    idle(2);
    chk("operr_sticky", op_err, 1);
    frame(8'h05, 8'h03, 8'h20, 0, 1, 0);
    chk("operr_after", op_err, 0);

    // Reset in WAIT_OP
    send_byte(8'h33);
    send_byte(8'h44);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_wait_op");
    tick();
    rst_n = 1'b1;
    last_op = '0;
    frame(8'h07, 8'h02, 8'h24, 0, 1, 0);
    chk("rst1_res", tx_data, 8'h02);

    // Reset in WAIT_TX: discarded frame produces no TX pulse
    send_byte(8'h0F);
    send_byte(8'h01);
    send_byte(8'h20);
    idle(3);
    chk("wtx_busy", busy, 1);
    t = tx_pulses;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_wait_tx");
    exp_tx++;
    tick();
    rst_n = 1'b1;
    last_op = '0;
    idle(3);
    chk("rst_no_tx", tx_pulses - t, 0);
    frame(8'hF0, 8'h0F, 8'h27, 0, 1, 0);
    chk("rst2_res", tx_data, 8'h00);

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 3) != 0)
        op = {2'($urandom), legal_ops[$urandom_range(0, 7)]};
      else
        op = 8'($urandom);
      frame(a, b, op, $urandom_range(0, TMO - 2), $urandom_range(0, 5), 0);
    end

    idle(3);
    chk("total_tx", tx_pulses, exp_tx);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
